// File: rtl/joint_rcservo.sv
// RC-servo joint driver: integrates a signed per-frame step into a clamped position and emits a hobby-servo PWM frame.
// Latency: position/feedback update on the frame-end edge; PWM is registered one clock behind the frame counter.
// Backpressure: none; the command is sampled once per frame and all outputs are free-running.
module joint_rcservo #(
  parameter int CLK_FREQ   = 48000000,
  parameter int SERVO_FREQ = 100
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [31:0] jointFreqCmd,
  output logic signed [31:0] jointFeedback,
  output logic               PWM
);

  // Frame geometry in clocks: 1.5 ms centre, +/-0.5 ms travel.
  localparam int FRAME  = CLK_FREQ / SERVO_FREQ;
  localparam int CENTER = int'(longint'(CLK_FREQ) * 3 / 2000);
  localparam int HALF   = CLK_FREQ / 2000;
  localparam int CW     = $clog2(FRAME);

  localparam logic [CW-1:0]     LAST     = CW'(FRAME - 1);
  localparam logic [31:0]       CENTER_U = 32'(CENTER);
  localparam logic signed [32:0] SUM_MAX = 33'(HALF);
  localparam logic signed [32:0] SUM_MIN = -SUM_MAX;
  localparam logic signed [31:0] POS_MAX = 32'(HALF);
  localparam logic signed [31:0] POS_MIN = -POS_MAX;

  logic [CW-1:0]      cnt_q, cnt_d;
  logic signed [31:0] pos_q, pos_d;
  logic [31:0]        wid_q, wid_d;
  logic               pwm_q, pwm_d;
  logic signed [32:0] sum;

  // Frame counter, position integration with saturation, and pulse comparator.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    pos_d = pos_q;
    wid_d = wid_q;
    // 33-bit sum so an extreme command cannot wrap before the clamp.
    sum   = {pos_q[31], pos_q} + {jointFreqCmd[31], jointFreqCmd};
    if (cnt_q == LAST) begin
      cnt_d = '0;
      if (sum > SUM_MAX) begin
        pos_d = POS_MAX;
      end else if (sum < SUM_MIN) begin
        pos_d = POS_MIN;
      end else begin
        pos_d = sum[31:0];
      end
      // Width always lands in [CENTER-HALF, CENTER+HALF], so it stays positive.
      wid_d = CENTER_U + $unsigned(pos_d);
    end
    // Pulse is high while the counter is below the width latched for this frame.
    pwm_d = (32'(cnt_q) < wid_q);
  end

  // State registers; reset drops PWM immediately without a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      pos_q <= '0;
      wid_q <= CENTER_U;
      pwm_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pos_q <= pos_d;
      wid_q <= wid_d;
      pwm_q <= pwm_d;
    end
  end

  assign jointFeedback = pos_q;
  assign PWM           = pwm_q;

endmodule

// File: tb/tb_joint_rcservo.sv
// Scoreboard bench for joint_rcservo with a scaled-down clock so whole frames fit a short run.
// FRAME=960, CENTER=144, HALF=48 clocks at CLK_FREQ=96000, SERVO_FREQ=100.
// Expected pulse widths and feedback are queued when commands are driven and checked per pulse.
module tb_joint_rcservo;

  localparam int CLK_FREQ   = 96000;
  localparam int SERVO_FREQ = 100;
  localparam int FRAME      = 960;
  localparam int CENTER     = 144;
  localparam int HALF       = 48;

  typedef struct {
    int wid;
    int fb;
  } exp_t;

  logic               clk;
  logic               rst_n;
  logic signed [31:0] jointFreqCmd;
  logic signed [31:0] jointFeedback;
  logic               PWM;

  joint_rcservo #(
    .CLK_FREQ  (CLK_FREQ),
    .SERVO_FREQ(SERVO_FREQ)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .jointFreqCmd (jointFreqCmd),
    .jointFeedback(jointFeedback),
    .PWM          (PWM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     total = 0;
  int     bad   = 0;
  exp_t   sb_q[$];
  longint pos_m = 0;
  int     rises = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Model: clamp the running position and queue the pulse that the next frame will produce.
  task automatic push_next(input longint cmd);
    exp_t e;
    pos_m = pos_m + cmd;
    if (pos_m > HALF) pos_m = HALF;
    if (pos_m < -HALF) pos_m = -HALF;
    e.wid = CENTER + int'(pos_m);
    e.fb  = int'(pos_m);
    sb_q.push_back(e);
  endtask

  task automatic wait_rise();
    int start;
    int n;
    start = rises;
    n = 0;
    while (rises == start && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    if (rises == start) chk("rise_timeout", 0, 1);
  endtask

  // Reset (possibly mid-pulse), then release and measure the first rise.
  task automatic do_reset();
    exp_t e;
    int   n;
    rst_n = 1'b0;
    jointFreqCmd = 0;
    #1;
    chk("rst_pwm_async", PWM, 0);
    sb_q.delete();
    pos_m = 0;
    e.wid = CENTER;
    e.fb  = 0;
    sb_q.push_back(e);
    repeat (3) @(negedge clk);
    chk("rst_pwm", PWM, 0);
    chk("rst_fb", jointFeedback, 0);
    #2;
    rst_n = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!PWM && n < 4);
    chk("rise_latency", n, 1);
  endtask

  // Pulse monitor: checks period, width and feedback of every complete pulse.
  initial begin
    int     cyc;
    int     rise_cyc;
    bit     have_rise;
    bit     pulse_ok;
    logic   pwm_prev;
    longint rise_fb;
    exp_t   e;
    cyc = 0;
    rise_cyc = 0;
    have_rise = 0;
    pulse_ok = 0;
    pwm_prev = 1'b0;
    rise_fb = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        have_rise = 0;
        pulse_ok  = 0;
        pwm_prev  = PWM;
      end else begin
        if (PWM && !pwm_prev) begin
          if (have_rise) chk("period", cyc - rise_cyc, FRAME);
          rise_cyc  = cyc;
          have_rise = 1;
          pulse_ok  = 1;
          rise_fb   = jointFeedback;
          rises++;
        end
        if (!PWM && pwm_prev && pulse_ok) begin
          pulse_ok = 0;
          if (sb_q.size() == 0) begin
            chk("sb_empty", 0, 1);
          end else begin
            e = sb_q.pop_front();
            chk("width", cyc - rise_cyc, e.wid);
            chk("feedback", rise_fb, e.fb);
          end
        end
        pwm_prev = PWM;
      end
    end
  end

  initial begin
    int cmds[7];
    int n;
    cmds = '{0, 8, 8, 8, 1000, 1000, -2000000000};
    rst_n = 1'b0;
    jointFreqCmd = 0;
    repeat (2) @(negedge clk);

    do_reset();
    for (int i = 0; i < 7; i++) begin
      jointFreqCmd = cmds[i];
      push_next(cmds[i]);
      wait_rise();
    end

    // Glitch the command mid-frame and restore it before frame end.
    jointFreqCmd = 5000;
    repeat (300) @(negedge clk);
    chk("fb_mid_frame", jointFeedback, pos_m);
    jointFreqCmd = 0;
    push_next(0);
    wait_rise();

    // Opposite-sign command moves off the negative limit.
    jointFreqCmd = 20;
    push_next(20);
    wait_rise();

    // Reset during a high pulse.
    repeat (50) @(negedge clk);
    chk("pwm_high_before_rst", PWM, 1);
    #2;
    do_reset();
    jointFreqCmd = 0;
    push_next(0);
    wait_rise();

    n = 0;
    while (sb_q.size() != 0 && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    chk("sb_drained", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
